multicycle_controller: RTL

Multicycle control FSM for the ASIP datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. It holds the architectural NZCV flag register and evaluates branch conditions. It stalls on a memory-ready handshake and traps illegal opcodes and memory timeouts into a sticky error state. It drives the shared-memory multicycle datapath directly: IR, PC, register file, ALU and memory enables and selects.

---
 rtl/multicycle_controller.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing, NZCV flag register,
// branch evaluation, memory-ready stalls with timeout, sticky error. Define PERF_CNT_EN for perf counters.
module multicycle_controller #(
  parameter int RDW         = 4,
  parameter int NFLAGS      = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int TOW         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        instr,
  input  logic [RDW-1:0]    rd,
  input  logic [NFLAGS-1:0] alu_flags,
  input  logic              mem_ready,
  output logic              ir_write,
  output logic              pc_write,
  output logic              adr_src,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_write,
  output logic [1:0]        reg_src,
  output logic [1:0]        imm_src,
  output logic              alu_src,
  output logic [1:0]        alu_control,
  output logic [1:0]        result_src,
  output logic [NFLAGS-1:0] flags,
  output logic              err,
  output logic [3:0]        state_o
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       retired_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_D  = 4'd2,
    S_WB_D    = 4'd3,
    S_MEM_ADR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WB  = 4'd6,
    S_MEM_WR  = 4'd7,
    S_BRANCH  = 4'd8,
    S_ERROR   = 4'd9
  } state_t;

  localparam logic [TOW-1:0] LP_TIMEOUT = TOW'(MEM_TIMEOUT);

  state_t            r_state;
  logic [TOW-1:0]    r_cnt;
  logic [NFLAGS-1:0] r_flags;

  logic [1:0]        w_type;
  logic              w_ib;
  logic              w_load;
  logic [1:0]        w_op;
  logic [2:0]        w_cond;
  logic [TOW-1:0]    w_cnt_inc;
  logic [NFLAGS-1:0] w_flag_mask;
  logic              w_taken;
  state_t            w_done_state;

  assign w_type    = instr[5:4];
  assign w_ib      = instr[3];
  assign w_op      = instr[2:1];
  assign w_load    = instr[1];
  assign w_cond    = instr[2:0];
  assign w_cnt_inc = r_cnt + 1'b1;

  // AND/ORR leave C and V alone; N, Z and any extra bits always follow the ALU.
  always_comb begin
    w_flag_mask = '1;
    if (w_op[1]) w_flag_mask[1:0] = 2'b00;
  end

  // Conditions read the architectural flags, never the live ALU flags.
  always_comb begin
    w_taken = 1'b0;
    case (w_cond)
      3'b000:  w_taken = r_flags[2];
      3'b001:  w_taken = !r_flags[2];
      3'b010:  w_taken = (r_flags[3] != r_flags[0]);
      3'b011:  w_taken = !r_flags[2] && (r_flags[3] == r_flags[0]);
      3'b100:  w_taken = (r_flags[3] == r_flags[0]);
      3'b101:  w_taken = r_flags[2] || (r_flags[3] != r_flags[0]);
      3'b110:  w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_done_state = S_FETCH;
    if (r_state == S_FETCH)  w_done_state = S_DECODE;
    if (r_state == S_MEM_RD) w_done_state = S_MEM_WB;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_flags <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        S_FETCH, S_MEM_RD, S_MEM_WR: begin
          if (mem_ready) begin
            r_cnt   <= '0;
            r_state <= w_done_state;
          end else if (w_cnt_inc == LP_TIMEOUT) begin
            r_cnt   <= '0;
            r_state <= S_ERROR;
          end else begin
            r_cnt   <= w_cnt_inc;
          end
        end
        S_DECODE: begin
          case (w_type)
            2'b00:   r_state <= S_EXEC_D;
            2'b01:   r_state <= S_MEM_ADR;
            2'b10:   r_state <= S_BRANCH;
            default: r_state <= S_ERROR;
          endcase
        end
        S_EXEC_D: begin
          r_flags <= (r_flags & ~w_flag_mask) | (alu_flags & w_flag_mask);
          r_state <= S_WB_D;
        end
        S_MEM_ADR: r_state <= w_load ? S_MEM_RD : S_MEM_WR;
        S_WB_D, S_MEM_WB, S_BRANCH: r_state <= S_FETCH;
        S_ERROR:   r_state <= S_ERROR;
        default:   r_state <= S_ERROR;
      endcase
    end
  end

  logic       w_ir_write, w_pc_write, w_adr_src, w_mem_read, w_mem_write, w_reg_write, w_alu_src;
  logic [1:0] w_reg_src, w_imm_src, w_alu_control, w_result_src;

  always_comb begin
    // NOTE: every decode output gets a default first so no latch is inferred on unlisted states.
    w_ir_write    = 1'b0;
    w_pc_write    = 1'b0;
    w_adr_src     = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_reg_write   = 1'b0;
    w_reg_src     = 2'b00;
    w_imm_src     = 2'b00;
    w_alu_src     = 1'b0;
    w_alu_control = 2'b00;
    w_result_src  = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
      end
      S_DECODE: begin
        w_reg_src = {(w_type == 2'b01) && !w_load, w_type == 2'b10};
        w_imm_src = w_type;
      end
      S_EXEC_D: begin
        w_alu_src     = w_ib;
        w_alu_control = w_op;
      end
      S_WB_D:    w_reg_write = !(&rd);
      S_MEM_ADR: w_alu_src   = 1'b1;
      S_MEM_RD: begin
        w_adr_src  = 1'b1;
        w_mem_read = 1'b1;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_result_src = 2'b01;
      end
      S_MEM_WR: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      S_BRANCH: begin
        w_pc_write   = w_taken;
        w_reg_write  = w_taken && w_ib;
        w_result_src = w_ib ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

  // Enables are gated by reset so an access in flight drops the instant reset asserts.
  assign ir_write    = w_ir_write  & reset;
  assign pc_write    = w_pc_write  & reset;
  assign mem_read    = w_mem_read  & reset;
  assign mem_write   = w_mem_write & reset;
  assign reg_write   = w_reg_write & reset;
  assign adr_src     = w_adr_src;
  assign reg_src     = w_reg_src;
  assign imm_src     = w_imm_src;
  assign alu_src     = w_alu_src;
  assign alu_control = w_alu_control;
  assign result_src  = w_result_src;
  assign flags       = r_flags;
  assign err         = (r_state == S_ERROR);
  assign state_o     = r_state;

`ifdef PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_retired_cnt;
  logic        w_retire;

  assign w_retire = (r_state == S_WB_D) || (r_state == S_MEM_WB) || (r_state == S_BRANCH) ||
                    ((r_state == S_MEM_WR) && mem_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
    end else begin
      if (r_state != S_ERROR) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_retire)           r_retired_cnt <= r_retired_cnt + 32'd1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign retired_cnt = r_retired_cnt;
`endif

endmodule
